// File: rtl/led_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pio_pkg
// Description : Register addresses and bus timing constants shared by the
//               LED PIO top level and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_PRESCALE = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLEAR    = 3'd5;

    localparam int READ_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/led_pio_blink_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pio_blink_if
// Description : Avalon-MM slave bus bundle for the LED PIO (no waitrequest).
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pio_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read, writedata,
        output readdata
    );

endinterface
`default_nettype wire

// File: rtl/led_blink_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_timer
// Description : Prescaler plus period counter producing the shared blink phase.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_timer #(
    parameter int PRE_W = 16,
    parameter int PER_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic [PRE_W-1:0] prescale,
    input  wire logic [PER_W-1:0] period,
    input  wire logic             restart,
    output logic                  phase
);

    logic [PRE_W-1:0] r_prescale_cnt;
    logic [PER_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic             w_tick;

    assign w_tick = (r_prescale_cnt == prescale);
    assign phase  = r_phase;

    // Equality compares keep both counters bounded by their limit registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prescale_cnt <= '0;
            r_blink_cnt    <= '0;
            r_phase        <= 1'b1;
        end else if (restart) begin
            r_prescale_cnt <= '0;
            r_blink_cnt    <= '0;
            r_phase        <= 1'b1;
        end else if (w_tick) begin
            r_prescale_cnt <= '0;
            if (r_blink_cnt == period) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_prescale_cnt <= r_prescale_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pio_blink.sv
`default_nettype none
// ============================================================================
// Module      : led_pio_blink
// Description : Avalon-MM output PIO with set/clear registers and per-bit blink.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pio_blink
    import led_pio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PRE_W = 16,
    parameter int PER_W = 16
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    led_pio_blink_if.slave  bus,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [PER_W-1:0] r_period;
    logic [PRE_W-1:0] r_prescale;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_rd;
    logic             w_restart;
    logic             w_phase;
    logic [31:0]      w_rdata;

    assign w_wr      = bus.chipselect & ~bus.write_n;
    assign w_rd      = bus.chipselect & bus.read;
    assign w_restart = w_wr && ((bus.address == ADDR_PERIOD) ||
                                (bus.address == ADDR_PRESCALE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_blink_en <= '0;
            r_period   <= '0;
            r_prescale <= '0;
        end else if (w_wr) begin
            case (bus.address)
                ADDR_DATA:     r_data     <= bus.writedata[WIDTH-1:0];
                ADDR_BLINK_EN: r_blink_en <= bus.writedata[WIDTH-1:0];
                ADDR_PERIOD:   r_period   <= bus.writedata[PER_W-1:0];
                ADDR_PRESCALE: r_prescale <= bus.writedata[PRE_W-1:0];
                ADDR_SET:      r_data     <= r_data | bus.writedata[WIDTH-1:0];
                ADDR_CLEAR:    r_data     <= r_data & ~bus.writedata[WIDTH-1:0];
                default:       ;
            endcase
        end
    end

    led_blink_timer #(
        .PRE_W (PRE_W),
        .PER_W (PER_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (r_prescale),
        .period   (r_period),
        .restart  (w_restart),
        .phase    (w_phase)
    );

    // Gated purely from flops so bus activity can never glitch the pins.
    assign out_port = r_data & (~r_blink_en | {WIDTH{w_phase}});

    always_comb begin
        w_rdata = '0;
        case (bus.address)
            ADDR_DATA:     w_rdata = 32'(r_data);
            ADDR_BLINK_EN: w_rdata = 32'(r_blink_en);
            ADDR_PERIOD:   w_rdata = 32'(r_period);
            ADDR_PRESCALE: w_rdata = 32'(r_prescale);
            ADDR_SET:      w_rdata = 32'(out_port);
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_led_pio_blink.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pio_blink
// Description : Scoreboard bench for led_pio_blink with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pio_blink;
    import led_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;

    int errors = 0;
    int checks = 0;

    logic [31:0] sb_q[$];
    bit          rd_valid = 1'b0;

    led_pio_blink_if bus_if ();

    led_pio_blink #(
        .WIDTH (8),
        .PRE_W (16),
        .PER_W (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Read response arrives READ_LATENCY cycles after the accepting edge.
    always @(posedge clk) rd_valid <= bus_if.chipselect && bus_if.read;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got readdata 0x%08h with no expected entry", bus_if.readdata);
            end else begin
                check("readdata", bus_if.readdata, sb_q.pop_front());
            end
        end
    end

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data, input logic cs);
        @(posedge clk); #1;
        bus_if.address    = addr;
        bus_if.writedata  = data;
        bus_if.chipselect = cs;
        bus_if.write_n    = 1'b0;
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.read       = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk); #1;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_out;
        bus_if.address    = '0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.read       = 1'b0;
        bus_if.writedata  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_port", {24'b0, out_port}, 32'h0);
        check("reset_readdata", bus_if.readdata, 32'h0);
        reset_n = 1'b1;

        for (int a = 0; a < 6; a++) bus_read(3'(a), 32'h0);
        check("idle_out_port", {24'b0, out_port}, 32'h0);

        // Plain data path and writedata truncation
        bus_write(ADDR_DATA, 32'h0000_00A5, 1'b1);
        check("data_a5_out", {24'b0, out_port}, 32'hA5);
        bus_read(ADDR_DATA, 32'h0000_00A5);
        bus_write(ADDR_DATA, 32'hFFFF_FF3C, 1'b1);
        check("data_3c_out", {24'b0, out_port}, 32'h3C);

        // Set / clear
        bus_write(ADDR_DATA, 32'h0F, 1'b1);
        bus_write(ADDR_SET, 32'hF0, 1'b1);
        check("set_out", {24'b0, out_port}, 32'hFF);
        bus_write(ADDR_CLEAR, 32'h81, 1'b1);
        check("clear_out", {24'b0, out_port}, 32'h7E);
        bus_read(ADDR_SET, 32'h7E);
        bus_read(ADDR_CLEAR, 32'h0);
        bus_read(ADDR_DATA, 32'h7E);

        // Blink: (1+1)*(2+1) = 6 clocks per phase; the PERIOD write restarts the timer
        bus_write(ADDR_DATA, 32'hFF, 1'b1);
        bus_write(ADDR_BLINK_EN, 32'h01, 1'b1);
        bus_write(ADDR_PRESCALE, 32'h1, 1'b1);
        bus_write(ADDR_PERIOD, 32'h2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            exp_out = ((k / 6) % 2 == 0) ? 32'hFF : 32'hFE;
            check($sformatf("blink6_k%0d", k), {24'b0, out_port}, exp_out);
            if (k < 19) begin
                @(posedge clk); #1;
            end
        end

        // Phase is 0 here; shortening PERIOD restarts with phase=1, toggling every 2 clocks
        bus_write(ADDR_PERIOD, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            exp_out = ((k / 2) % 2 == 0) ? 32'hFF : 32'hFE;
            check($sformatf("blink2_k%0d", k), {24'b0, out_port}, exp_out);
            @(posedge clk); #1;
        end

        // Asynchronous reset in mid-blink
        reset_n = 1'b0;
        #1;
        check("async_reset_out", {24'b0, out_port}, 32'h0);
        check("async_reset_rd", bus_if.readdata, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int a = 0; a < 6; a++) bus_read(3'(a), 32'h0);

        // Unmapped address and deselected accesses change nothing
        bus_write(ADDR_DATA, 32'h55, 1'b1);
        bus_write(3'd6, 32'hFF, 1'b1);
        bus_write(ADDR_DATA, 32'h00, 1'b0);
        bus_write(ADDR_SET, 32'hFF, 1'b0);
        bus_write(ADDR_BLINK_EN, 32'hFF, 1'b0);
        check("cs0_out", {24'b0, out_port}, 32'h55);
        bus_read(3'd6, 32'h0);
        bus_read(ADDR_DATA, 32'h55);
        @(posedge clk); #1;
        bus_if.address = ADDR_CLEAR;
        bus_if.read    = 1'b1;
        @(posedge clk); #1;
        bus_if.read    = 1'b0;
        check("cs0_read_hold", bus_if.readdata, 32'h55);
        bus_read(ADDR_BLINK_EN, 32'h0);

        // Register readback with truncation to register width
        bus_write(ADDR_PERIOD, 32'hFFFF_1234, 1'b1);
        bus_write(ADDR_PRESCALE, 32'h0000_BEEF, 1'b1);
        bus_write(ADDR_BLINK_EN, 32'h0000_013C, 1'b1);
        bus_read(ADDR_PERIOD, 32'h1234);
        bus_read(ADDR_PRESCALE, 32'hBEEF);
        bus_read(ADDR_BLINK_EN, 32'h3C);
        check("readback_out", {24'b0, out_port}, 32'h55 & ~32'h3C | (32'h55 & 32'h3C));

        repeat (READ_LATENCY + 2) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
